// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA scan controller:
//   - coord_t: 10-bit unsigned pixel/line coordinate
//   - 640x480@60 timing constants, used as the controller's parameter defaults
//   - in_range(): half-open interval test used by the sync/blank decodes
// Optional feature macro used elsewhere in this slice: VGA_FRAME_COUNT_EN.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixel-clock periods.
    localparam int unsigned H_TOTAL_DEF      = 800;
    localparam int unsigned H_VISIBLE_DEF    = 640;
    localparam int unsigned H_SYNC_START_DEF = 656;
    localparam int unsigned H_SYNC_END_DEF   = 752;

    // Vertical timing, in lines.
    localparam int unsigned V_TOTAL_DEF      = 525;
    localparam int unsigned V_VISIBLE_DEF    = 480;
    localparam int unsigned V_SYNC_START_DEF = 490;
    localparam int unsigned V_SYNC_END_DEF   = 492;

    // Width of the optional frame counter.
    localparam int unsigned FRAME_COUNT_W = 16;

    // True when lo <= v < hi.
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// -----------------------------------------------------------------------------
// vga_scan_controller_if
// Bundles the scan controller's video-timing outputs.
//   pixel_clk   : Clk/2 pixel clock for the DAC
//   hs, vs      : horizontal / vertical sync, active-low
//   blank       : 1 only inside the visible region
//   DrawX/DrawY : current pixel column / line
//   frame_start : one-Clk pulse at the start of every frame
//   frame_count : frame counter (only when VGA_FRAME_COUNT_EN is defined)
// Modports: master = the controller (drives), slave = a video consumer.
// -----------------------------------------------------------------------------
interface vga_scan_controller_if;
    import vga_timing_pkg::*;

    logic   pixel_clk;
    logic   hs;
    logic   vs;
    logic   blank;
    coord_t DrawX;
    coord_t DrawY;
    logic   frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_COUNT_W-1:0] frame_count;
`endif

`ifdef VGA_FRAME_COUNT_EN
    modport master (
        output pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start, frame_count
    );
    modport slave (
        input  pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start, frame_count
    );
`else
    modport master (
        output pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start
    );
    modport slave (
        input  pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start
    );
`endif

endinterface

// File: rtl/vga_wrap_counter.sv
// -----------------------------------------------------------------------------
// vga_wrap_counter
// Generic 10-bit up-counter that wraps from i_max back to 0.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset, clears the count
//   i_enable : advance the count on this edge
//   i_max    : terminal value; the count goes i_max -> 0
//   o_count  : current (registered) count
//   o_wrap   : combinational, high on an enabled edge that wraps to 0
// Used for both the column and the line counter; chaining o_wrap of the
// column counter into i_enable of the line counter gives the raster scan.
// -----------------------------------------------------------------------------
module vga_wrap_counter
    import vga_timing_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_enable,
    input  coord_t i_max,
    output coord_t o_count,
    output logic   o_wrap
);

    coord_t r_count;
    coord_t w_count_next;
    logic   w_at_max;

    assign w_at_max = (r_count == i_max);

    always_comb begin
        w_count_next = r_count;
        if (i_enable) begin
            w_count_next = w_at_max ? '0 : r_count + coord_t'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_enable && w_at_max;

endmodule

// File: rtl/vga_scan_controller.sv
// -----------------------------------------------------------------------------
// vga_scan_controller
// VGA raster timing generator (default 640x480@60 from a 50 MHz clock).
//   i_clk : system clock, all state updates on the rising edge
//   i_rst : asynchronous active-high reset
//   vif   : vga_scan_controller_if.master carrying pixel_clk, hs, vs, blank,
//           DrawX, DrawY, frame_start and, with VGA_FRAME_COUNT_EN defined,
//           the 16-bit frame_count.
// Optional feature: define VGA_FRAME_COUNT_EN to add frame_count, a wrapping
// count of frame_start pulses. Without it the port and register are absent.
//
// pixel_clk toggles every Clk. The counters advance on the edges where
// pixel_clk is currently 1, so after reset the first advance happens on the
// second rising edge. hs/vs/blank are pure decodes of the registered
// counters, so they line up with DrawX/DrawY with no extra latency.
// -----------------------------------------------------------------------------
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned H_VISIBLE    = H_VISIBLE_DEF,
    parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
    parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
    parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
    parameter int unsigned V_VISIBLE    = V_VISIBLE_DEF,
    parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
    parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    vga_scan_controller_if.master  vif
);

    // Timing constants narrowed to coordinate width for the comparators.
    localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
    localparam coord_t H_VIS = coord_t'(H_VISIBLE);
    localparam coord_t H_SS  = coord_t'(H_SYNC_START);
    localparam coord_t H_SE  = coord_t'(H_SYNC_END);
    localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);
    localparam coord_t V_VIS = coord_t'(V_VISIBLE);
    localparam coord_t V_SS  = coord_t'(V_SYNC_START);
    localparam coord_t V_SE  = coord_t'(V_SYNC_END);

    logic   r_pixel_clk;
    logic   r_frame_start;
    logic   w_pixel_en;
    coord_t w_hc;
    coord_t w_vc;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_hs;
    logic   w_vs;
    logic   w_blank;

    // ---------------------------------------------------------------------
    // Pixel clock and advance strobe
    // ---------------------------------------------------------------------
    // Sampling the current pixel_clk value (not the next one) is what puts
    // the first counter step on the second edge after reset.
    assign w_pixel_en = r_pixel_clk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pixel_clk <= 1'b0;
        end else begin
            r_pixel_clk <= ~r_pixel_clk;
        end
    end

    // ---------------------------------------------------------------------
    // Column / line counters
    // ---------------------------------------------------------------------
    vga_wrap_counter u_hcount (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_pixel_en),
        .i_max    (H_MAX),
        .o_count  (w_hc),
        .o_wrap   (w_h_wrap)
    );

    // The line counter steps only on the column wrap, so its own wrap marks
    // the (H_TOTAL-1, V_TOTAL-1) -> (0, 0) transition.
    vga_wrap_counter u_vcount (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_h_wrap),
        .i_max    (V_MAX),
        .o_count  (w_vc),
        .o_wrap   (w_v_wrap)
    );

    // ---------------------------------------------------------------------
    // Frame start pulse
    // ---------------------------------------------------------------------
    // Registered copy of the frame wrap: high for the single Clk in which the
    // counters first read (0, 0). The next edge has pixel_en low, so the
    // wrap cannot repeat and the pulse is exactly one Clk wide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // ---------------------------------------------------------------------
    // Optional frame counter
    // ---------------------------------------------------------------------
    // Steps on the same edge that raises frame_start, so the new count is
    // visible while frame_start is high. Wraps 0xFFFF -> 0 naturally.
    logic [FRAME_COUNT_W-1:0] r_frame_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_count <= '0;
        end else if (w_v_wrap) begin
            r_frame_count <= r_frame_count + FRAME_COUNT_W'(1);
        end
    end

    assign vif.frame_count = r_frame_count;
`endif

    // ---------------------------------------------------------------------
    // Sync and blank decodes
    // ---------------------------------------------------------------------
    assign w_hs    = ~in_range(w_hc, H_SS, H_SE);
    assign w_vs    = ~in_range(w_vc, V_SS, V_SE);
    assign w_blank = (w_hc < H_VIS) && (w_vc < V_VIS);

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign vif.pixel_clk   = r_pixel_clk;
    assign vif.hs          = w_hs;
    assign vif.vs          = w_vs;
    assign vif.blank       = w_blank;
    assign vif.DrawX       = w_hc;
    assign vif.DrawY       = w_vc;
    assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_controller
// Two controllers share clock and reset: one at the default 640x480 timing,
// one with a small 40x20 raster so whole frames fit in a short run. The
// reference model maps "rising edges since reset release" straight to the
// expected outputs with division/modulo arithmetic.
// With VGA_FRAME_COUNT_EN defined the frame counter is also exercised.
// -----------------------------------------------------------------------------
module tb_vga_scan_controller;
    import vga_timing_pkg::*;

    typedef struct {
        int unsigned ht, hv, hss, hse, vt, vv, vss, vse;
    } timing_t;

    typedef struct {
        bit          px, hs, vs, bl, fs;
        int unsigned x, y;
    } exp_t;

    typedef struct {
        int unsigned k;
        bit          px;
        int unsigned x, y;
        bit          hs, vs, bl, fs;
    } vec_t;

    localparam int NVEC = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned k   = 0;   // rising edges since reset was released
    int          checks = 0;
    int          errors = 0;
    timing_t     t_d;
    timing_t     t_s;
    vec_t        vecs [NVEC];

    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    vga_scan_controller_if if_d ();
    vga_scan_controller_if if_s ();

    vga_scan_controller dut_d (
        .i_clk (clk),
        .i_rst (rst),
        .vif   (if_d)
    );

    vga_scan_controller #(
        .H_TOTAL      (40),
        .H_VISIBLE    (32),
        .H_SYNC_START (33),
        .H_SYNC_END   (37),
        .V_TOTAL      (20),
        .V_VISIBLE    (15),
        .V_SYNC_START (16),
        .V_SYNC_END   (18)
    ) dut_s (
        .i_clk (clk),
        .i_rst (rst),
        .vif   (if_s)
    );

    // Reference: every second edge is one pixel step; position follows from
    // the number of steps taken.
    function automatic exp_t model(int unsigned kk, timing_t t);
        exp_t        e;
        int unsigned n;
        n    = kk / 2;
        e.px = (kk % 2) == 1;
        e.x  = n % t.ht;
        e.y  = (n / t.ht) % t.vt;
        e.hs = !(e.x >= t.hss && e.x < t.hse);
        e.vs = !(e.y >= t.vss && e.y < t.vse);
        e.bl = (e.x < t.hv) && (e.y < t.vv);
        e.fs = ((kk % 2) == 0) && (n != 0) && ((n % (t.ht * t.vt)) == 0);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e,
                              input logic px, input logic hs, input logic vs,
                              input logic bl, input logic fs,
                              input logic [9:0] x, input logic [9:0] y);
        cmp({tag, ".pixel_clk"},   {31'b0, px}, {31'b0, e.px});
        cmp({tag, ".hs"},          {31'b0, hs}, {31'b0, e.hs});
        cmp({tag, ".vs"},          {31'b0, vs}, {31'b0, e.vs});
        cmp({tag, ".blank"},       {31'b0, bl}, {31'b0, e.bl});
        cmp({tag, ".frame_start"}, {31'b0, fs}, {31'b0, e.fs});
        cmp({tag, ".DrawX"},       {22'b0, x},  e.x);
        cmp({tag, ".DrawY"},       {22'b0, y},  e.y);
    endtask

    task automatic check_model(input string tag);
        exp_t ed;
        exp_t es;
        ed = model(k, t_d);
        es = model(k, t_s);
        check_outs({tag, "/d"}, ed, if_d.pixel_clk, if_d.hs, if_d.vs, if_d.blank,
                   if_d.frame_start, if_d.DrawX, if_d.DrawY);
        check_outs({tag, "/s"}, es, if_s.pixel_clk, if_s.hs, if_s.vs, if_s.blank,
                   if_s.frame_start, if_s.DrawX, if_s.DrawY);
    endtask

    // Fixed reset values, independent of the model.
    task automatic check_reset_consts(input string tag);
        exp_t r;
        r = '{px: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b1, fs: 1'b0, x: 0, y: 0};
        check_outs({tag, "/rd"}, r, if_d.pixel_clk, if_d.hs, if_d.vs, if_d.blank,
                   if_d.frame_start, if_d.DrawX, if_d.DrawY);
        check_outs({tag, "/rs"}, r, if_s.pixel_clk, if_s.hs, if_s.vs, if_s.blank,
                   if_s.frame_start, if_s.DrawX, if_s.DrawY);
    endtask

    task automatic tick();
        @(negedge clk);
        check_model("tick");
    endtask

    // Hand-derived checkpoints for the default timing after a reset release.
    task automatic run_table(input string tag);
        for (int i = 0; i < NVEC; i++) begin
            exp_t e;
            int   guard;
            guard = 0;
            while (k < vecs[i].k && guard < 5000) begin
                tick();
                guard++;
            end
            e = '{px: vecs[i].px, hs: vecs[i].hs, vs: vecs[i].vs, bl: vecs[i].bl,
                  fs: vecs[i].fs, x: vecs[i].x, y: vecs[i].y};
            check_outs($sformatf("%s.v%0d", tag, i), e, if_d.pixel_clk, if_d.hs, if_d.vs,
                       if_d.blank, if_d.frame_start, if_d.DrawX, if_d.DrawY);
        end
    endtask

    initial begin
        int guard;
        int hs_low, first_hs_x, first_bl_x, xchg;
        int fs_cnt, fs_d_cnt, fs_wide, vs_low, vs_bad;
        int unsigned last_fs_k;
        logic [9:0] prev_x;
        logic       prev_fs;

        t_d = '{800, 640, 656, 752, 525, 480, 490, 492};
        t_s = '{40, 32, 33, 37, 20, 15, 16, 18};

        //          k     px    x    y  hs    vs    bl    fs
        vecs[0]  = '{0,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3,    1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1279, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1280, 1'b0, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1311, 1'b1, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1312, 1'b0, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1503, 1'b1, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1504, 1'b0, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1599, 1'b1, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1600, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{2200, 1'b0, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with no clock edge in between: async behaviour.
        #2 rst = 1'b1;
        #1 check_reset_consts("por");
        repeat (3) tick();
        check_reset_consts("por_hold");
        rst = 1'b0;

        run_table("t1");

        // One full line of the default raster (line 2), k = 3201..4800.
        guard = 0;
        while (k < 3200 && guard < 5000) begin
            tick();
            guard++;
        end
        hs_low = 0; first_hs_x = -1; first_bl_x = -1; xchg = 0;
        prev_x = if_d.DrawX;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (!if_d.hs) begin
                hs_low++;
                if (first_hs_x < 0) first_hs_x = int'(if_d.DrawX);
            end
            if (!if_d.blank && first_bl_x < 0) first_bl_x = int'(if_d.DrawX);
            if (if_d.DrawX != prev_x) xchg++;
            prev_x = if_d.DrawX;
        end
        cmp("line.hs_low_clks", hs_low, 192);
        cmp("line.hs_first_x", first_hs_x, 656);
        cmp("line.blank_fall_x", first_bl_x, 640);
        cmp("line.drawx_changes", xchg, 800);
`ifdef VGA_FRAME_COUNT_EN
        cmp("fc.after_3_frames", {16'b0, if_s.frame_count}, 3);
`endif

        // Three frames of the small raster, k = 4801..9600.
        fs_cnt = 0; fs_d_cnt = 0; fs_wide = 0; vs_low = 0; vs_bad = 0;
        last_fs_k = 0; prev_fs = 1'b0;
        for (int i = 0; i < 4800; i++) begin
            tick();
            if (if_s.frame_start) begin
                fs_cnt++;
                if (last_fs_k != 0) cmp("frame.spacing", k - last_fs_k, 1600);
                last_fs_k = k;
            end
            if (prev_fs && if_s.frame_start) fs_wide++;
            prev_fs = if_s.frame_start;
            if (if_d.frame_start) fs_d_cnt++;
            if (!if_s.vs) begin
                vs_low++;
                if (!(if_s.DrawY >= 10'd16 && if_s.DrawY < 10'd18)) vs_bad++;
            end
        end
        cmp("frame.pulses", fs_cnt, 3);
        cmp("frame.wide_pulses", fs_wide, 0);
        cmp("frame.default_pulses", fs_d_cnt, 0);
        cmp("frame.vs_low_clks", vs_low, 480);
        cmp("frame.vs_outside_window", vs_bad, 0);

        // Mid-frame reset at DrawX=300 of the default raster.
        guard = 0;
        while (k < 10200 && guard < 5000) begin
            tick();
            guard++;
        end
        cmp("mid.DrawX", {22'b0, if_d.DrawX}, 300);
        cmp("mid.DrawY", {22'b0, if_d.DrawY}, 6);
        @(posedge clk);
        #5 rst = 1'b1;
        #1 check_reset_consts("mid.async");
        check_model("mid.async");
        tick();
        tick();
        rst = 1'b0;
        run_table("t2");

        // Random run lengths and random reset phase within the cycle.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(20, 3000)) tick();
            @(posedge clk);
            #($urandom_range(1, 9)) rst = 1'b1;
            #1 check_reset_consts("rnd.async");
            repeat ($urandom_range(1, 3)) tick();
            rst = 1'b0;
        end
        repeat (200) tick();

`ifdef VGA_FRAME_COUNT_EN
        // Preload 0xFFFF and expect the next frame_start to wrap it to 0.
        force dut_s.r_frame_count = 16'hFFFF;
        tick();
        release dut_s.r_frame_count;
        cmp("fc.preload", {16'b0, if_s.frame_count}, 32'hFFFF);
        guard = 0;
        while (!if_s.frame_start && guard < 1700) begin
            tick();
            guard++;
        end
        cmp("fc.frame_start_seen", {31'b0, if_s.frame_start}, 1);
        cmp("fc.wrapped", {16'b0, if_s.frame_count}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
